// File: rtl/seq_muldiv_if.sv
// Request/result bundle for seq_muldiv. The master drives the request
// (start/op/A/B); the slave (the engine) drives status and results.
interface seq_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             div_zero;

  modport master (
    output start, op, A, B,
    input  busy, done, HI, LO, div_zero
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, HI, LO, div_zero
  );
endinterface

// File: rtl/seq_muldiv.sv
// seq_muldiv: multi-cycle signed/unsigned multiply and divide engine.
// Shift-add multiply and restoring divide on operand magnitudes, followed by
// a single sign-fix cycle that writes HI/LO.
// Optional divider: define SEQ_MULDIV_DIV_EN to build the divide datapath.
// Without it, DIV/DIVU finish immediately with HI=LO=0 and div_zero=1.
module seq_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input logic        Clock,
  input logic        Resetn,
  seq_muldiv_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  // Accumulator / remainder, multiplier / quotient, multiplicand / divisor.
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mq;
  logic [WIDTH-1:0] r_mcand;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_neg_lo;
  logic             r_neg_hi;
  logic             r_dz;

  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic               w_last;

  assign w_accept   = bus.start && ((r_state == StIdle) || (r_state == StDone));
  // Operands are treated as signed only for MUL/DIV (op[0] = 0).
  assign w_a_neg    = ~bus.op[0] & bus.A[WIDTH-1];
  assign w_b_neg    = ~bus.op[0] & bus.B[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -bus.A : bus.A;
  assign w_b_mag    = w_b_neg ? -bus.B : bus.B;
  assign w_mul_sum  = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_mcand} : '0);
  assign w_prod     = {r_acc, r_mq};
  assign w_prod_neg = -w_prod;
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

`ifdef SEQ_MULDIV_DIV_EN
  logic [WIDTH:0]   w_shift;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_diff;
  logic             w_b_zero;

  assign w_shift  = {r_acc, r_mq[WIDTH-1]};
  assign w_q_bit  = (w_shift >= {1'b0, r_mcand});
  // A kept difference is below the divisor, so W bits hold it exactly.
  assign w_diff   = w_shift[WIDTH-1:0] - r_mcand;
  assign w_b_zero = (bus.B == '0);
`endif

  // Control FSM and datapath: capture, iterate, sign-fix, report.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= StIdle;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_acc      <= '0;
      r_mq       <= '0;
      r_mcand    <= '0;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_dz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (w_accept) begin
            r_busy   <= 1'b1;
            r_is_div <= bus.op[1];
            r_cnt    <= '0;
            if (bus.op[1]) begin
`ifdef SEQ_MULDIV_DIV_EN
              if (w_b_zero) begin
                // Divide by zero: results are fixed, skip iteration.
                r_acc    <= bus.A;
                r_mq     <= '1;
                r_neg_lo <= 1'b0;
                r_neg_hi <= 1'b0;
                r_dz     <= 1'b1;
                r_state  <= StFix;
              end else begin
                r_acc    <= '0;
                r_mq     <= w_a_mag;
                r_mcand  <= w_b_mag;
                r_neg_lo <= w_a_neg ^ w_b_neg;
                r_neg_hi <= w_a_neg;
                r_dz     <= 1'b0;
                r_state  <= StCalc;
              end
`else
              // No divider: report the op as illegal with zero results.
              r_acc    <= '0;
              r_mq     <= '0;
              r_neg_lo <= 1'b0;
              r_neg_hi <= 1'b0;
              r_dz     <= 1'b1;
              r_state  <= StFix;
`endif
            end else begin
              r_acc    <= '0;
              r_mq     <= w_b_mag;
              r_mcand  <= w_a_mag;
              r_neg_lo <= w_a_neg ^ w_b_neg;
              r_neg_hi <= 1'b0;
              r_dz     <= 1'b0;
              r_state  <= StCalc;
            end
          end else begin
            r_state <= StIdle;
          end
        end
        StCalc: begin
`ifdef SEQ_MULDIV_DIV_EN
          if (r_is_div) begin
            r_acc <= w_q_bit ? w_diff : w_shift[WIDTH-1:0];
            r_mq  <= {r_mq[WIDTH-2:0], w_q_bit};
          end else begin
            r_acc <= w_mul_sum[WIDTH:1];
            r_mq  <= {w_mul_sum[0], r_mq[WIDTH-1:1]};
          end
`else
          r_acc <= w_mul_sum[WIDTH:1];
          r_mq  <= {w_mul_sum[0], r_mq[WIDTH-1:1]};
`endif
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= StFix;
          end
        end
        StFix: begin
          if (r_is_div) begin
            r_lo <= r_neg_lo ? -r_mq : r_mq;
            r_hi <= r_neg_hi ? -r_acc : r_acc;
          end else begin
            {r_hi, r_lo} <= r_neg_lo ? w_prod_neg : w_prod;
          end
          r_div_zero <= r_dz;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= StDone;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.HI       = r_hi;
  assign bus.LO       = r_lo;
  assign bus.div_zero = r_div_zero;

endmodule
